// File: rtl/glip_uart_egress_mux_pkg.sv
// Shared constants, state encoding and control-byte helper for the GLIP UART
// egress multiplexer.
package glip_uart_egress_mux_pkg;

  localparam logic [7:0]  ESCAPE_BYTE   = 8'hFE;
  localparam int unsigned CREDIT_WIDTH  = 14;
  localparam int unsigned CTRL_FLAG_BIT = 0;
  localparam int unsigned CTRL_SEL_BIT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ESC     = 2'd1,
    ST_CRED_HI = 2'd2,
    ST_CRED_LO = 2'd3
  } state_e;

  // Credit control byte: select=0 (credit), upper credit bits, control flag=1.
  function automatic logic [7:0] credit_hi_byte(input logic [CREDIT_WIDTH-1:0] c);
    logic [7:0] b;
    b                                   = '0;
    b[CTRL_FLAG_BIT]                    = 1'b1;
    b[CTRL_SEL_BIT]                     = 1'b0;
    b[CTRL_SEL_BIT-1:CTRL_FLAG_BIT+1]   = c[CREDIT_WIDTH-1:8];
    return b;
  endfunction

endpackage

// File: rtl/glip_uart_egress_mux.sv
// Merges escaped user bytes and credit messages into one registered byte
// stream towards the UART transmitter.
module glip_uart_egress_mux
  import glip_uart_egress_mux_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    transfer,
  input  logic                    credit_en,
  input  logic [CREDIT_WIDTH-1:0] credit_val,
  output logic                    credit_ready
);

  state_e                  state_q, state_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    pending_q, pending_d;
  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;

  logic load;
  logic credit_take;
  logic pend_eff;

  always_comb begin
    load        = ~out_valid_q | out_ready;
    credit_take = credit_en & ~pending_q;
    // A credit captured this cycle already outranks a simultaneous user byte.
    pend_eff    = pending_q | credit_take;

    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pending_d   = pending_q;
    credit_d    = credit_q;

    if (credit_take) begin
      credit_d  = credit_val;
      pending_d = 1'b1;
    end

    if (load) begin
      case (state_q)
        ST_IDLE: begin
          if (pend_eff) begin
            out_data_d  = ESCAPE_BYTE;
            out_valid_d = 1'b1;
            state_d     = ST_CRED_HI;
          end else if (in_valid) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            state_d     = (in_data == ESCAPE_BYTE) ? ST_ESC : ST_IDLE;
          end else begin
            out_valid_d = 1'b0;
          end
        end
        ST_ESC: begin
          out_data_d  = ESCAPE_BYTE;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        ST_CRED_HI: begin
          out_data_d  = credit_hi_byte(credit_q);
          out_valid_d = 1'b1;
          state_d     = ST_CRED_LO;
        end
        ST_CRED_LO: begin
          out_data_d  = credit_q[7:0];
          out_valid_d = 1'b1;
          pending_d   = 1'b0;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    in_ready     = ~rst & load & (state_q == ST_IDLE) & ~pend_eff;
    transfer     = in_valid & in_ready;
    credit_ready = ~pending_q;
    out_data     = out_data_q;
    out_valid    = out_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      credit_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pending_q   <= pending_d;
      credit_q    <= credit_d;
    end
  end

endmodule

// File: tb/tb_glip_uart_egress_mux.sv
// Scoreboard bench for glip_uart_egress_mux: directed vectors push expected
// output bytes, a negedge monitor pops and compares accepted output bytes.
module tb_glip_uart_egress_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        transfer;
  logic        credit_en;
  logic [13:0] credit_val;
  logic        credit_ready;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int stall_cnt = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int pop_cyc[$];

  glip_uart_egress_mux dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .transfer     (transfer),
    .credit_en    (credit_en),
    .credit_val   (credit_val),
    .credit_ready (credit_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: an output byte is consumed at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (transfer) xfer_cnt++;
      if (in_valid && out_ready && !in_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", out_data);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int  n;
    logic done;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        n++;
        if (n > 50) begin
          checks++; errors++;
          $display("FAIL send_timeout actual=no_in_ready required=in_ready");
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_credit(input logic [13:0] c);
    int  n;
    logic done;
    credit_val = c;
    credit_en  = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (credit_ready) done = 1'b1;
      else begin
        n++;
        if (n > 50) begin
          checks++; errors++;
          $display("FAIL credit_timeout actual=no_credit_ready required=credit_ready");
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    credit_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int x0, s0;
    logic [7:0] head;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, s0;
    logic [7:0] head;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    credit_en = 1'b0; credit_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_credit_ready", {31'd0, credit_ready}, 1);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_transfer", {31'd0, transfer}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 41,FE,42 -> 41,FE,FE,42 back to back
    x0 = xfer_cnt; s0 = stall_cnt; pop_cyc.delete();
    exp_q.push_back(8'h41); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFE); exp_q.push_back(8'h42);
    send(8'h41); send(8'hFE); send(8'h42);
    drain();
    chk("esc_transfers", xfer_cnt - x0, 3);
    chk("esc_in_ready_low", stall_cnt - s0, 1);
    chk("esc_pop_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) chk("esc_consecutive", pop_cyc[3] - pop_cyc[0], 3);

    // credit 3FFF -> FE,7F,FF
    exp_q.push_back(8'hFE); exp_q.push_back(8'h7F); exp_q.push_back(8'hFF);
    send_credit(14'h3FFF);
    @(negedge clk);
    chk("credit_busy", {31'd0, credit_ready}, 0);
    drain();
    chk("credit_free", {31'd0, credit_ready}, 1);

    // credit and escaped user byte together: credit first
    x0 = xfer_cnt;
    exp_q.push_back(8'hFE); exp_q.push_back(8'h25); exp_q.push_back(8'h34);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFE);
    fork
      send(8'hFE);
      send_credit(14'h1234);
    join
    drain();
    chk("race_transfers", xfer_cnt - x0, 1);

    // escape pair is not split by a following credit; low byte FE unescaped
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFE); exp_q.push_back(8'hFE);
    exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
    send(8'hFE);
    send_credit(14'h00FE);
    drain();

    // zero credit
    exp_q.push_back(8'hFE); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    send_credit(14'h0000);
    drain();

    // backpressure for 5 cycles mid-stream
    x0 = xfer_cnt;
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    fork
      begin
        send(8'h10); send(8'h11); send(8'h12); send(8'h13);
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          head = (exp_q.size() != 0) ? exp_q[0] : 8'hXX;
          chk("stall_valid", {31'd0, out_valid}, 1);
          chk("stall_data", {24'd0, out_data}, {24'd0, head});
          chk("stall_in_ready", {31'd0, in_ready}, 0);
          chk("stall_transfer", {31'd0, transfer}, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_transfers", xfer_cnt - x0, 4);

    // reset in the middle of a credit message
    exp_q.push_back(8'hFE);
    send_credit(14'h0155);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_credit_ready", {31'd0, credit_ready}, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(8'h41);
    send(8'h41);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
